// File: rtl/rename_regfile_if.sv
// Issue/ROB/commit bundle for the architectural register file and rename table.
// The master side drives strobes and operands; the slave side (the register file) answers with operands.
interface rename_regfile_if #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5,
  parameter int ROB_W = 4
);
  logic             rdy;
  logic             is_valid;
  logic [REG_W-1:0] is_rs1;
  logic [REG_W-1:0] is_rs2;
  logic [REG_W-1:0] is_rd;
  logic [ROB_W-1:0] is_tag;
  logic [XLEN-1:0]  is_rs1_val;
  logic [XLEN-1:0]  is_rs2_val;
  logic             is_rs1_rdy;
  logic             is_rs2_rdy;
  logic [ROB_W-1:0] rob_q1;
  logic [ROB_W-1:0] rob_q2;
  logic             rob_rdy1;
  logic             rob_rdy2;
  logic [XLEN-1:0]  rob_val1;
  logic [XLEN-1:0]  rob_val2;
  logic             cm_valid;
  logic [REG_W-1:0] cm_rd;
  logic [ROB_W-1:0] cm_tag;
  logic [XLEN-1:0]  cm_val;
  logic             flush;
  logic [REG_W:0]   busy_cnt;

  modport master (
    output rdy, is_valid, is_rs1, is_rs2, is_rd, is_tag,
           rob_rdy1, rob_rdy2, rob_val1, rob_val2,
           cm_valid, cm_rd, cm_tag, cm_val, flush,
    input  is_rs1_val, is_rs2_val, is_rs1_rdy, is_rs2_rdy,
           rob_q1, rob_q2, busy_cnt
  );

  modport slave (
    input  rdy, is_valid, is_rs1, is_rs2, is_rd, is_tag,
           rob_rdy1, rob_rdy2, rob_val1, rob_val2,
           cm_valid, cm_rd, cm_tag, cm_val, flush,
    output is_rs1_val, is_rs2_val, is_rs1_rdy, is_rs2_rdy,
           rob_q1, rob_q2, busy_cnt
  );
endinterface

// File: rtl/rename_regfile.sv
// Architectural register file with per-register busy/ROB-tag rename state.
// Sources resolve to a committed value, a commit/ROB bypass, or a pending ROB tag.
module rename_regfile #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int REG_W = 5,
  parameter int ROB_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  rename_regfile_if.slave  rf_if
);

  logic [NREG-1:0][XLEN-1:0]  regs_q, regs_d;
  logic [NREG-1:0][ROB_W-1:0] tag_q,  tag_d;
  logic [NREG-1:0]            busy_q, busy_d;
  logic [REG_W:0]             busy_cnt_q, busy_cnt_d;

  logic [REG_W-1:0] src_s     [2];
  logic             rob_rdy_s [2];
  logic [XLEN-1:0]  rob_val_s [2];
  logic [XLEN-1:0]  val_s     [2];
  logic             rdy_s     [2];
  logic [ROB_W-1:0] qtag_s    [2];
  logic             issue_fire_s;
  logic             commit_fire_s;

  // Register 0 and indices beyond the file are neither stored nor renamed.
  function automatic logic idx_ok(input logic [REG_W-1:0] idx);
    return (idx != {REG_W{1'b0}}) && (int'(idx) < NREG);
  endfunction

  function automatic logic [REG_W:0] popcount(input logic [NREG-1:0] v);
    logic [REG_W:0] c;
    c = {(REG_W+1){1'b0}};
    for (int i = 0; i < NREG; i++) begin
      c = c + {{REG_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  assign src_s[0]     = rf_if.is_rs1;
  assign src_s[1]     = rf_if.is_rs2;
  assign rob_rdy_s[0] = rf_if.rob_rdy1;
  assign rob_rdy_s[1] = rf_if.rob_rdy2;
  assign rob_val_s[0] = rf_if.rob_val1;
  assign rob_val_s[1] = rf_if.rob_val2;

  // Source operand resolution from pre-update state: committed, commit bypass, ROB bypass, or tag.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      val_s[n]  = {XLEN{1'b0}};
      rdy_s[n]  = 1'b1;
      qtag_s[n] = {ROB_W{1'b0}};
      if (idx_ok(src_s[n])) begin
        qtag_s[n] = tag_q[src_s[n]];
        if (!busy_q[src_s[n]]) begin
          val_s[n] = regs_q[src_s[n]];
        end else if (rf_if.cm_valid && (rf_if.cm_rd == src_s[n]) &&
                     (rf_if.cm_tag == tag_q[src_s[n]])) begin
          val_s[n] = rf_if.cm_val;
        end else if (rob_rdy_s[n]) begin
          val_s[n] = rob_val_s[n];
        end else begin
          val_s[n] = XLEN'(tag_q[src_s[n]]);
          rdy_s[n] = 1'b0;
        end
      end else begin
        val_s[n] = {XLEN{1'b0}};
      end
    end
  end

  assign rf_if.is_rs1_val = val_s[0];
  assign rf_if.is_rs2_val = val_s[1];
  assign rf_if.is_rs1_rdy = rdy_s[0];
  assign rf_if.is_rs2_rdy = rdy_s[1];
  assign rf_if.rob_q1     = qtag_s[0];
  assign rf_if.rob_q2     = qtag_s[1];
  assign rf_if.busy_cnt   = busy_cnt_q;

  assign issue_fire_s  = rf_if.is_valid && idx_ok(rf_if.is_rd) && !rf_if.flush;
  assign commit_fire_s = rf_if.cm_valid && idx_ok(rf_if.cm_rd);

  // Next state: commit writes the value always; issue outranks commit on busy/tag; flush clears busy.
  always_comb begin
    regs_d = regs_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (commit_fire_s) begin
      regs_d[rf_if.cm_rd] = rf_if.cm_val;
      if (busy_q[rf_if.cm_rd] && (tag_q[rf_if.cm_rd] == rf_if.cm_tag) &&
          !(issue_fire_s && (rf_if.is_rd == rf_if.cm_rd))) begin
        busy_d[rf_if.cm_rd] = 1'b0;
      end else begin
        busy_d[rf_if.cm_rd] = busy_q[rf_if.cm_rd];
      end
    end else begin
      regs_d = regs_q;
    end
    if (issue_fire_s) begin
      busy_d[rf_if.is_rd] = 1'b1;
      tag_d[rf_if.is_rd]  = rf_if.is_tag;
    end else begin
      tag_d = tag_q;
    end
    if (rf_if.flush) begin
      busy_d = {NREG{1'b0}};
    end else begin
      busy_d = busy_d;
    end
    busy_cnt_d = popcount(busy_d);
  end

  // State registers: synchronous reset dominates, rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q     <= '0;
      tag_q      <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else if (rf_if.rdy) begin
      regs_q     <= regs_d;
      tag_q      <= tag_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

endmodule

// File: tb/tb_rename_regfile.sv
// Directed test-plan steps followed by random traffic, checked against an array-based model.
module tb_rename_regfile;
  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int REG_W = 5;
  localparam int ROB_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  rename_regfile_if #(.XLEN(XLEN), .REG_W(REG_W), .ROB_W(ROB_W)) bus ();
  rename_regfile #(.XLEN(XLEN), .NREG(NREG), .REG_W(REG_W), .ROB_W(ROB_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .rf_if (bus)
  );

  // Reference model: architectural values, busy flags and tags as plain arrays.
  logic [XLEN-1:0]  m_val  [NREG];
  bit               m_busy [NREG];
  logic [ROB_W-1:0] m_tag  [NREG];

  task automatic expect_eq(input string name, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic idle();
    bus.rdy = 1'b1; bus.is_valid = 1'b0; bus.is_rd = '0; bus.is_tag = '0;
    bus.rob_rdy1 = 1'b0; bus.rob_rdy2 = 1'b0; bus.rob_val1 = '0; bus.rob_val2 = '0;
    bus.cm_valid = 1'b0; bus.cm_rd = '0; bus.cm_tag = '0; bus.cm_val = '0; bus.flush = 1'b0;
  endtask

  function automatic void model_read(input int s, input bit rr, input logic [XLEN-1:0] rv,
                                     output logic [XLEN-1:0] v, output bit r, output logic [ROB_W-1:0] q);
    q = (s == 0) ? '0 : m_tag[s];
    r = 1'b1;
    if (s == 0 || !m_busy[s]) v = (s == 0) ? '0 : m_val[s];
    else if (bus.cm_valid && int'(bus.cm_rd) == s && bus.cm_tag == m_tag[s]) v = bus.cm_val;
    else if (rr) v = rv;
    else begin v = XLEN'(m_tag[s]); r = 1'b0; end
  endfunction

  task automatic check_comb();
    logic [XLEN-1:0] v; bit r; logic [ROB_W-1:0] q;
    #1;
    model_read(int'(bus.is_rs1), bus.rob_rdy1, bus.rob_val1, v, r, q);
    expect_eq("rs1_val", bus.is_rs1_val, v);
    expect_eq("rs1_rdy", XLEN'(bus.is_rs1_rdy), XLEN'(r));
    expect_eq("rob_q1", XLEN'(bus.rob_q1), XLEN'(q));
    model_read(int'(bus.is_rs2), bus.rob_rdy2, bus.rob_val2, v, r, q);
    expect_eq("rs2_val", bus.is_rs2_val, v);
    expect_eq("rs2_rdy", XLEN'(bus.is_rs2_rdy), XLEN'(r));
    expect_eq("rob_q2", XLEN'(bus.rob_q2), XLEN'(q));
  endtask

  // Apply one clock edge to model and DUT, then compare the busy count.
  task automatic tick();
    int cnt;
    int ird, crd;
    bit issue;
    ird = int'(bus.is_rd);
    crd = int'(bus.cm_rd);
    issue = bus.is_valid && ird != 0 && !bus.flush;
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin m_val[i] = '0; m_busy[i] = 0; m_tag[i] = '0; end
    end else if (bus.rdy) begin
      if (bus.cm_valid && crd != 0) begin
        m_val[crd] = bus.cm_val;
        if (m_busy[crd] && m_tag[crd] == bus.cm_tag && !(issue && ird == crd)) m_busy[crd] = 0;
      end
      if (issue) begin m_busy[ird] = 1; m_tag[ird] = bus.is_tag; end
      if (bus.flush) for (int i = 0; i < NREG; i++) m_busy[i] = 0;
    end
    @(posedge clk);
    #1;
    cnt = 0;
    for (int i = 0; i < NREG; i++) cnt += int'(m_busy[i]);
    expect_eq("busy_cnt", XLEN'(bus.busy_cnt), XLEN'(cnt));
  endtask

  task automatic issue(input int rd, input int tag);
    idle(); bus.is_valid = 1'b1; bus.is_rd = REG_W'(rd); bus.is_tag = ROB_W'(tag);
    check_comb(); tick();
  endtask

  task automatic commit(input int rd, input int tag, input logic [XLEN-1:0] val);
    idle(); bus.cm_valid = 1'b1; bus.cm_rd = REG_W'(rd); bus.cm_tag = ROB_W'(tag); bus.cm_val = val;
    check_comb(); tick();
  endtask

  initial begin
    idle();
    bus.is_rs1 = '0; bus.is_rs2 = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset values
    bus.is_rs1 = 5'd3; bus.is_rs2 = 5'd0;
    check_comb();
    expect_eq("rst_x3_val", bus.is_rs1_val, 32'h0);
    expect_eq("rst_x3_rdy", XLEN'(bus.is_rs1_rdy), 32'h1);
    expect_eq("rst_x0_val", bus.is_rs2_val, 32'h0);
    expect_eq("rst_cnt", XLEN'(bus.busy_cnt), 32'h0);

    // Rename then ROB bypass
    issue(5, 7);
    idle(); bus.is_rs1 = 5'd5;
    check_comb();
    expect_eq("tag_val", bus.is_rs1_val, 32'h7);
    expect_eq("tag_rdy", XLEN'(bus.is_rs1_rdy), 32'h0);
    expect_eq("tag_q1", XLEN'(bus.rob_q1), 32'h7);
    bus.rob_rdy1 = 1'b1; bus.rob_val1 = 32'hDEAD;
    check_comb();
    expect_eq("rob_byp_val", bus.is_rs1_val, 32'hDEAD);
    expect_eq("rob_byp_rdy", XLEN'(bus.is_rs1_rdy), 32'h1);

    // Commit bypass
    idle(); bus.is_rs2 = 5'd5; bus.cm_valid = 1'b1; bus.cm_rd = 5'd5; bus.cm_tag = 4'd7; bus.cm_val = 32'h1234;
    check_comb();
    expect_eq("cm_byp_val", bus.is_rs2_val, 32'h1234);
    expect_eq("cm_byp_rdy", XLEN'(bus.is_rs2_rdy), 32'h1);
    tick();
    idle(); check_comb();
    expect_eq("cm_after_val", bus.is_rs2_val, 32'h1234);
    expect_eq("cm_after_cnt", XLEN'(bus.busy_cnt), 32'h0);

    // Stale-tag commit leaves the newer rename busy
    bus.is_rs1 = 5'd5;
    issue(5, 2); issue(5, 9);
    commit(5, 2, 32'hAA);
    idle(); check_comb();
    expect_eq("stale_val", bus.is_rs1_val, 32'h9);
    expect_eq("stale_rdy", XLEN'(bus.is_rs1_rdy), 32'h0);
    commit(5, 9, 32'hBB);
    idle(); check_comb();
    expect_eq("new_val", bus.is_rs1_val, 32'hBB);
    expect_eq("new_rdy", XLEN'(bus.is_rs1_rdy), 32'h1);

    // Issue wins busy/tag over a same-cycle commit of the older tag
    bus.is_rs1 = 5'd6;
    issue(6, 1);
    idle(); bus.is_valid = 1'b1; bus.is_rd = 5'd6; bus.is_tag = 4'd3;
    bus.cm_valid = 1'b1; bus.cm_rd = 5'd6; bus.cm_tag = 4'd1; bus.cm_val = 32'h55;
    check_comb(); tick();
    idle(); check_comb();
    expect_eq("iw_rdy", XLEN'(bus.is_rs1_rdy), 32'h0);
    expect_eq("iw_q1", XLEN'(bus.rob_q1), 32'h3);

    // Flush with same-cycle issue and commit
    issue(1, 1); issue(2, 2); issue(3, 3);
    expect_eq("pre_flush_cnt", XLEN'(bus.busy_cnt), 32'h4);
    idle(); bus.flush = 1'b1; bus.is_valid = 1'b1; bus.is_rd = 5'd4; bus.is_tag = 4'd5;
    bus.cm_valid = 1'b1; bus.cm_rd = 5'd1; bus.cm_tag = 4'd1; bus.cm_val = 32'h77;
    check_comb(); tick();
    idle(); bus.is_rs1 = 5'd4; bus.is_rs2 = 5'd1;
    check_comb();
    expect_eq("flush_cnt", XLEN'(bus.busy_cnt), 32'h0);
    expect_eq("flush_x4_rdy", XLEN'(bus.is_rs1_rdy), 32'h1);
    expect_eq("flush_x1_val", bus.is_rs2_val, 32'h77);
    bus.is_rs1 = 5'd6;
    check_comb();
    expect_eq("flush_x6_val", bus.is_rs1_val, 32'h55);

    // Freeze
    idle(); bus.rdy = 1'b0; bus.is_valid = 1'b1; bus.is_rd = 5'd7; bus.is_tag = 4'd4;
    bus.cm_valid = 1'b1; bus.cm_rd = 5'd2; bus.cm_tag = 4'd2; bus.cm_val = 32'h99;
    check_comb(); tick();
    idle(); bus.is_rs1 = 5'd7; bus.is_rs2 = 5'd2;
    check_comb();
    expect_eq("frz_cnt", XLEN'(bus.busy_cnt), 32'h0);
    expect_eq("frz_x7_rdy", XLEN'(bus.is_rs1_rdy), 32'h1);
    expect_eq("frz_x2_val", bus.is_rs2_val, 32'h0);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      int r;
      idle();
      bus.rdy      = ($urandom_range(0, 9) != 0);
      bus.is_valid = $urandom_range(0, 1);
      bus.is_rd    = REG_W'($urandom_range(0, 7));
      bus.is_tag   = ROB_W'($urandom);
      bus.is_rs1   = REG_W'($urandom_range(0, 7));
      bus.is_rs2   = REG_W'($urandom_range(0, 7));
      bus.rob_rdy1 = ($urandom_range(0, 3) == 0);
      bus.rob_rdy2 = ($urandom_range(0, 3) == 0);
      bus.rob_val1 = $urandom;
      bus.rob_val2 = $urandom;
      r = $urandom_range(0, 7);
      bus.cm_valid = $urandom_range(0, 1);
      bus.cm_rd    = REG_W'(r);
      bus.cm_tag   = ($urandom_range(0, 3) == 0) ? ROB_W'($urandom) : m_tag[r];
      bus.cm_val   = $urandom;
      bus.flush    = ($urandom_range(0, 24) == 0);
      rst          = ($urandom_range(0, 199) == 0);
      check_comb();
      tick();
      rst = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
